stp_ctrl: RTL and testbench
===========================

STP_CTRL -- requirements
Module: stp_ctrl

Interface
REQ-001 SHALL have parameter STEP_PERIOD_CYCLES, default 2400, meaning clock cycles per phase transition; legal values are 8 or more.
REQ-002 SHALL have parameter POSITION_BITS, default 11, meaning the width of the position and target fields.
REQ-003 SHALL have parameter HOME_TIMEOUT_STEPS, default 1100, meaning the maximum number of CCW steps in HOME_SEEK.
REQ-004 SHALL have port clock  in  1  single clock domain.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  in  1  command request.
REQ-007 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 SHALL have port cmd_home  in  1  1 = homing command, 0 = move command.
REQ-009 SHALL have port cmd_target  in  POSITION_BITS  absolute move target, unsigned.
REQ-010 SHALL have port limit_sw_near_in  in  1  near limit switch, asynchronous.
REQ-011 SHALL have port limit_sw_far_in  in  1  far limit switch, asynchronous.
REQ-012 SHALL have port error_clear_in  in  1  clears ERROR.
REQ-013 SHALL have port stp_en_out  out  1  driver enable.
REQ-014 SHALL have port stp_pa_out  out  1  phase A.
REQ-015 SHALL have port stp_pb_out  out  1  phase B.
REQ-016 SHALL have port position_out  out  POSITION_BITS  steps from the home point.
REQ-017 SHALL have port homed_out  out  1  position is valid.
REQ-018 SHALL have port busy_out  out  1  a command is executing.
REQ-019 SHALL have port done_out  out  1  one-cycle completion pulse.
REQ-020 SHALL have port error_out  out  1  controller is in ERROR.

Function
REQ-021 SHALL synchronize both limit inputs with 2-flop synchronizers; all limit decisions use the synchronized values.
REQ-022 SHALL implement states IDLE, HOME_SEEK, HOME_BACKOFF, MOVE and ERROR.
REQ-023 SHALL assert cmd_ready only in IDLE; after acceptance, cmd_ready SHALL be low on the next cycle.
REQ-024 SHALL drive the phase pair {pa,pb} through 00→10→11→01→00 for each CW step (position +1) and through the reverse order for each CCW step (position −1).
REQ-025 SHALL make exactly one phase transition per step tick; ticks occur every STEP_PERIOD_CYCLES cycles while in HOME_SEEK, HOME_BACKOFF or MOVE.
REQ-026 SHALL restart the tick counter on command acceptance, so the first transition occurs STEP_PERIOD_CYCLES cycles after acceptance.
REQ-027 SHALL sample limits and evaluate the position only at tick boundaries, before deciding on the next step.
REQ-028 SHALL hold the phases when no step is taken.
REQ-029 SHALL set stp_en_out high from acceptance of the first command onward, and SHALL force it low in ERROR and in reset.
REQ-030 On an accepted homing command, SHALL clear homed_out and enter HOME_SEEK, or enter HOME_BACKOFF directly if near is already asserted.
REQ-031 In HOME_SEEK, SHALL step CCW until near is asserted, then enter HOME_BACKOFF; if HOME_TIMEOUT_STEPS steps pass without near, SHALL enter ERROR.
REQ-032 In HOME_BACKOFF, SHALL step CW until near is deasserted at a tick, then set position to 0, set homed_out to 1, pulse done_out and return to IDLE.
REQ-033 On an accepted move command with homed_out at 0, SHALL enter ERROR.
REQ-034 On a move with target equal to position, SHALL pulse done_out on the cycle after acceptance without any step.
REQ-035 On a move, SHALL step CW if target > position and CCW if target < position, until position equals target, then pulse done_out and return to IDLE.
REQ-036 During a move, SHALL enter ERROR without stepping if far is asserted at a tick before a CW step, or near is asserted at a tick before a CCW step; position then holds its last value.
REQ-037 SHALL keep position arithmetic unsigned, and a CCW step at position 0 SHALL be treated as a near-limit error.
REQ-038 On entering ERROR, SHALL clear homed_out and busy_out and set error_out; on error_clear_in, SHALL leave ERROR for IDLE with error_out low.
REQ-039 SHALL hold busy_out high in HOME_SEEK, HOME_BACKOFF and MOVE, and low otherwise.

Reset
REQ-040 On reset, SHALL asynchronously force state IDLE, stp_en_out 0, phases 00, position 0, homed_out 0, busy_out 0, done_out 0, error_out 0 and tick counter 0.
REQ-041 On a reset mid-command, SHALL abandon the command with no completion pulse.

Verification
REQ-042 SHALL pass: emulator counter 0, near asserted, home command → HOME_BACKOFF entered directly, 20 CW steps, position 0, homed_out 1, done_out pulse.
REQ-043 SHALL pass: after homing, move to 500 → 500 CW steps, emulator counter 520, position_out 500, one done_out pulse.
REQ-044 SHALL pass: at position 500, move to 100 → 400 CCW steps, each phase sequence 00→01→11→10→00, emulator counter 120.
REQ-045 SHALL pass: move to 1005 → error_out 1 at position 1000, stp_en_out 0, homed_out 0; error_clear_in → IDLE, cmd_ready 1.
REQ-046 SHALL pass: move command before homing → ERROR with no phase change; reset asserted mid-move → all outputs return to reset values in the same cycle.
REQ-047 SHALL pass: near held low with HOME_TIMEOUT_STEPS = 50 → ERROR after 50 CCW steps.

Source files
------------

// File: rtl/stp_ctrl.sv
// stp_ctrl: two-phase stepper motor controller with homing against a near
// limit switch, absolute moves, limit-switch protection and a sticky ERROR
// state. Phase outputs follow the quadrature order 00->10->11->01 for CW.
module stp_ctrl #(
  parameter int STEP_PERIOD_CYCLES = 2400,
  parameter int POSITION_BITS      = 11,
  parameter int HOME_TIMEOUT_STEPS = 1100
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_home,
  input  logic [POSITION_BITS-1:0] cmd_target,
  input  logic                     limit_sw_near_in,
  input  logic                     limit_sw_far_in,
  input  logic                     error_clear_in,
  output logic                     stp_en_out,
  output logic                     stp_pa_out,
  output logic                     stp_pb_out,
  output logic [POSITION_BITS-1:0] position_out,
  output logic                     homed_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic                     error_out
);

  localparam int TICK_W = $clog2(STEP_PERIOD_CYCLES);
  localparam int HOME_W = $clog2(HOME_TIMEOUT_STEPS + 1);
  localparam logic [TICK_W-1:0]        TICK_LAST  = TICK_W'(STEP_PERIOD_CYCLES - 1);
  localparam logic [TICK_W-1:0]        TICK_ONE   = TICK_W'(1);
  localparam logic [HOME_W-1:0]        HOME_LIMIT = HOME_W'(HOME_TIMEOUT_STEPS);
  localparam logic [HOME_W-1:0]        HOME_ONE   = HOME_W'(1);
  localparam logic [POSITION_BITS-1:0] POS_ZERO   = {POSITION_BITS{1'b0}};
  localparam logic [POSITION_BITS-1:0] POS_ONE    = POSITION_BITS'(1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_HOME_SEEK    = 3'd1,
    ST_HOME_BACKOFF = 3'd2,
    ST_MOVE         = 3'd3,
    ST_ERROR        = 3'd4
  } state_t;

  // Phase index 0..3 maps onto the {pa,pb} quadrature code.
  function automatic logic [1:0] phase_code(input logic [1:0] idx);
    case (idx)
      2'd0:    phase_code = 2'b00;
      2'd1:    phase_code = 2'b10;
      2'd2:    phase_code = 2'b11;
      2'd3:    phase_code = 2'b01;
      default: phase_code = 2'b00;
    endcase
  endfunction

  state_t                     state_r, state_nxt_s;
  logic                       near_meta_r, near_sync_r, far_meta_r, far_sync_r;
  logic [TICK_W-1:0]          tick_cnt_r;
  logic [HOME_W-1:0]          home_cnt_r;
  logic [POSITION_BITS-1:0]   target_r, position_r;
  logic [1:0]                 phase_idx_r, phase_idx_nxt_s;
  logic                       cmd_ready_r, en_r, pa_r, pb_r, homed_r, busy_r, done_r, error_r;
  logic                       accept_s, active_s, tick_s;
  logic                       step_cw_s, step_ccw_s, done_s;

  assign accept_s = cmd_valid & cmd_ready_r;
  assign active_s = (state_r == ST_HOME_SEEK) || (state_r == ST_HOME_BACKOFF) || (state_r == ST_MOVE);
  assign tick_s   = active_s && (tick_cnt_r == TICK_LAST);

  // Two-flop synchronizers for the asynchronous limit switches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      near_meta_r <= 1'b0;
      near_sync_r <= 1'b0;
      far_meta_r  <= 1'b0;
      far_sync_r  <= 1'b0;
    end else begin
      near_meta_r <= limit_sw_near_in;
      near_sync_r <= near_meta_r;
      far_meta_r  <= limit_sw_far_in;
      far_sync_r  <= far_meta_r;
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decision; limits and position are only looked at on a tick.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s)                      state_nxt_s = ST_IDLE;
        else if (cmd_home)                  state_nxt_s = near_sync_r ? ST_HOME_BACKOFF : ST_HOME_SEEK;
        else if (!homed_r)                  state_nxt_s = ST_ERROR;
        else if (cmd_target == position_r)  state_nxt_s = ST_IDLE;
        else                                state_nxt_s = ST_MOVE;
      end
      ST_HOME_SEEK: begin
        if (!tick_s)                        state_nxt_s = ST_HOME_SEEK;
        else if (near_sync_r)               state_nxt_s = ST_HOME_BACKOFF;
        else if (home_cnt_r == HOME_LIMIT)  state_nxt_s = ST_ERROR;
        else                                state_nxt_s = ST_HOME_SEEK;
      end
      ST_HOME_BACKOFF: begin
        if (tick_s && !near_sync_r)         state_nxt_s = ST_IDLE;
        else                                state_nxt_s = ST_HOME_BACKOFF;
      end
      ST_MOVE: begin
        if (!tick_s)                        state_nxt_s = ST_MOVE;
        else if (position_r == target_r)    state_nxt_s = ST_IDLE;
        else if (target_r > position_r)     state_nxt_s = far_sync_r ? ST_ERROR : ST_MOVE;
        else if (near_sync_r || (position_r == POS_ZERO)) state_nxt_s = ST_ERROR;
        else                                state_nxt_s = ST_MOVE;
      end
      ST_ERROR: begin
        if (error_clear_in)                 state_nxt_s = ST_IDLE;
        else                                state_nxt_s = ST_ERROR;
      end
      default:                              state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-cycle actions: which way to step and when a command completes.
  always_comb begin
    step_cw_s  = 1'b0;
    step_ccw_s = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !cmd_home && homed_r && (cmd_target == position_r)) done_s = 1'b1;
        else done_s = 1'b0;
      end
      ST_HOME_SEEK: begin
        if (tick_s && !near_sync_r && (home_cnt_r != HOME_LIMIT)) step_ccw_s = 1'b1;
        else step_ccw_s = 1'b0;
      end
      ST_HOME_BACKOFF: begin
        if (tick_s && near_sync_r)  step_cw_s = 1'b1;
        else if (tick_s)            done_s    = 1'b1;
        else                        step_cw_s = 1'b0;
      end
      ST_MOVE: begin
        if (!tick_s)                           done_s     = 1'b0;
        else if (position_r == target_r)       done_s     = 1'b1;
        else if (target_r > position_r)        step_cw_s  = !far_sync_r;
        else                                   step_ccw_s = !near_sync_r && (position_r != POS_ZERO);
      end
      ST_ERROR:                                done_s     = 1'b0;
      default:                                 done_s     = 1'b0;
    endcase
  end

  // Next phase index: one quarter turn per step, held otherwise.
  always_comb begin
    phase_idx_nxt_s = phase_idx_r;
    if (step_cw_s)       phase_idx_nxt_s = phase_idx_r + 2'd1;
    else if (step_ccw_s) phase_idx_nxt_s = phase_idx_r - 2'd1;
    else                 phase_idx_nxt_s = phase_idx_r;
  end

  // Datapath and registered outputs; all flags follow the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt_r  <= {TICK_W{1'b0}};
      home_cnt_r  <= {HOME_W{1'b0}};
      target_r    <= POS_ZERO;
      position_r  <= POS_ZERO;
      phase_idx_r <= 2'd0;
      pa_r        <= 1'b0;
      pb_r        <= 1'b0;
      cmd_ready_r <= 1'b1;
      en_r        <= 1'b0;
      homed_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      if (accept_s)                  tick_cnt_r <= {TICK_W{1'b0}};
      else if (tick_s || !active_s)  tick_cnt_r <= {TICK_W{1'b0}};
      else                           tick_cnt_r <= tick_cnt_r + TICK_ONE;

      if (accept_s)                  home_cnt_r <= {HOME_W{1'b0}};
      else if (step_ccw_s && (state_r == ST_HOME_SEEK)) home_cnt_r <= home_cnt_r + HOME_ONE;
      else                           home_cnt_r <= home_cnt_r;

      if (accept_s)                  target_r <= cmd_target;
      else                           target_r <= target_r;

      // Position is only tracked once homed; homing re-zeroes it at the end.
      if ((state_r == ST_HOME_BACKOFF) && done_s)      position_r <= POS_ZERO;
      else if ((state_r == ST_MOVE) && step_cw_s)      position_r <= position_r + POS_ONE;
      else if ((state_r == ST_MOVE) && step_ccw_s)     position_r <= position_r - POS_ONE;
      else                                             position_r <= position_r;

      phase_idx_r <= phase_idx_nxt_s;
      {pa_r, pb_r} <= phase_code(phase_idx_nxt_s);

      if (state_nxt_s == ST_ERROR)                 homed_r <= 1'b0;
      else if (accept_s && cmd_home)               homed_r <= 1'b0;
      else if ((state_r == ST_HOME_BACKOFF) && done_s) homed_r <= 1'b1;
      else                                         homed_r <= homed_r;

      if (state_nxt_s == ST_ERROR)   en_r <= 1'b0;
      else if (accept_s)             en_r <= 1'b1;
      else                           en_r <= en_r;

      cmd_ready_r <= (state_nxt_s == ST_IDLE) && !accept_s;
      busy_r      <= (state_nxt_s == ST_HOME_SEEK) || (state_nxt_s == ST_HOME_BACKOFF) ||
                     (state_nxt_s == ST_MOVE);
      error_r     <= (state_nxt_s == ST_ERROR);
      done_r      <= done_s;
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign stp_en_out   = en_r;
  assign stp_pa_out   = pa_r;
  assign stp_pb_out   = pb_r;
  assign position_out = position_r;
  assign homed_out    = homed_r;
  assign busy_out     = busy_r;
  assign done_out     = done_r;
  assign error_out    = error_r;

endmodule

// File: tb/tb_stp_ctrl.sv
// tb_stp_ctrl: directed bench for stp_ctrl with a small motor emulator that
// decodes phase transitions into a step counter and drives the limit
// switches from it (near below 20, far at 1020 and above).
module tb_stp_ctrl;
  localparam int P  = 8;
  localparam int PB = 11;
  localparam int HT = 50;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_home = 1'b0;
  logic [PB-1:0] cmd_target = '0;
  logic          limit_sw_near_in, limit_sw_far_in;
  logic          error_clear_in = 1'b0;
  logic          stp_en_out, stp_pa_out, stp_pb_out;
  logic [PB-1:0] position_out;
  logic          homed_out, busy_out, done_out, error_out;

  int checks = 0;
  int failures = 0;

  int   emu_pos = 0, cw_total = 0, ccw_total = 0, bad_total = 0, done_total = 0;
  logic emu_load = 1'b0;
  int   emu_load_val = 0;
  logic near_force_low = 1'b0;
  logic [1:0] prev_idx = 2'd0;
  logic [1:0] cur_idx, step_d;

  stp_ctrl #(.STEP_PERIOD_CYCLES(P), .POSITION_BITS(PB), .HOME_TIMEOUT_STEPS(HT)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_home(cmd_home), .cmd_target(cmd_target),
    .limit_sw_near_in(limit_sw_near_in), .limit_sw_far_in(limit_sw_far_in),
    .error_clear_in(error_clear_in), .stp_en_out(stp_en_out),
    .stp_pa_out(stp_pa_out), .stp_pb_out(stp_pb_out), .position_out(position_out),
    .homed_out(homed_out), .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] ph_idx(input logic a, input logic b);
    case ({a, b})
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  assign cur_idx = ph_idx(stp_pa_out, stp_pb_out);
  assign step_d  = cur_idx - prev_idx;
  assign limit_sw_near_in = near_force_low ? 1'b0 : (emu_pos < 20);
  assign limit_sw_far_in  = (emu_pos >= 1020);

  // Motor emulator: +1 per CW quarter step, -1 per CCW, counts illegal jumps.
  always @(posedge clock) begin
    if (!reset) begin
      if (step_d == 2'd1) begin
        cw_total <= cw_total + 1;
        emu_pos  <= emu_pos + 1;
      end else if (step_d == 2'd3) begin
        ccw_total <= ccw_total + 1;
        emu_pos   <= emu_pos - 1;
      end else if (step_d == 2'd2) begin
        bad_total <= bad_total + 1;
      end
      if (done_out) done_total <= done_total + 1;
    end
    if (emu_load) emu_pos <= emu_load_val;
    prev_idx <= cur_idx;
  end

  task automatic chk_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic home, input int tgt);
    int n;
    n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk_val("ready_before_cmd", int'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_home   = home;
    cmd_target = PB'(tgt);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    chk_val("ready_low_after_accept", int'(cmd_ready), 0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int n;
    start = done_total;
    n = 0;
    while (done_total == start && error_out == 1'b0 && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk_val(tag, done_total - start, 1);
    chk_val({tag, "_pulse_width"}, int'(done_out), 0);
  endtask

  task automatic wait_err(input string tag, input int budget);
    int n;
    n = 0;
    while (error_out == 1'b0 && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk_val(tag, int'(error_out), 1);
  endtask

  task automatic clear_err(input string tag);
    @(negedge clock);
    error_clear_in = 1'b1;
    @(posedge clock);
    #1;
    chk_val({tag, "_ready"}, int'(cmd_ready), 1);
    chk_val({tag, "_error_low"}, int'(error_out), 0);
    @(negedge clock);
    error_clear_in = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cw0, ccw0, bad0, dn0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk_val("rst_en", int'(stp_en_out), 0);
    chk_val("rst_phase", int'({stp_pa_out, stp_pb_out}), 0);
    chk_val("rst_pos", int'(position_out), 0);
    chk_val("rst_flags", int'({homed_out, busy_out, done_out, error_out}), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk_val("idle_ready", int'(cmd_ready), 1);

    // Move before homing: immediate ERROR, no phase activity
    cw0 = cw_total; ccw0 = ccw_total; bad0 = bad_total;
    send_cmd(1'b0, 5);
    chk_val("unhomed_err", int'(error_out), 1);
    chk_val("unhomed_en", int'(stp_en_out), 0);
    chk_val("unhomed_busy", int'(busy_out), 0);
    repeat (3 * P) @(posedge clock);
    #1;
    chk_val("unhomed_no_steps", (cw_total - cw0) + (ccw_total - ccw0) + (bad_total - bad0), 0);
    clear_err("unhomed_clear");

    // Homing with near already asserted: straight to backoff, 20 CW steps
    cw0 = cw_total; ccw0 = ccw_total;
    send_cmd(1'b1, 0);
    chk_val("home_busy", int'(busy_out), 1);
    chk_val("home_en", int'(stp_en_out), 1);
    wait_done("home_done", 40 * P);
    chk_val("home_cw", cw_total - cw0, 20);
    chk_val("home_ccw", ccw_total - ccw0, 0);
    chk_val("home_pos", int'(position_out), 0);
    chk_val("home_homed", int'(homed_out), 1);
    chk_val("home_emu", emu_pos, 20);
    chk_val("home_busy_end", int'(busy_out), 0);

    // Move to 500
    cw0 = cw_total; ccw0 = ccw_total;
    send_cmd(1'b0, 500);
    chk_val("mv500_busy", int'(busy_out), 1);
    wait_done("mv500_done", 600 * P);
    chk_val("mv500_cw", cw_total - cw0, 500);
    chk_val("mv500_ccw", ccw_total - ccw0, 0);
    chk_val("mv500_emu", emu_pos, 520);
    chk_val("mv500_pos", int'(position_out), 500);

    // Move to current position: done next cycle, no step
    cw0 = cw_total; ccw0 = ccw_total; dn0 = done_total;
    send_cmd(1'b0, 500);
    chk_val("same_done", int'(done_out), 1);
    chk_val("same_busy", int'(busy_out), 0);
    repeat (2 * P) @(posedge clock);
    #1;
    chk_val("same_no_steps", (cw_total - cw0) + (ccw_total - ccw0), 0);
    chk_val("same_one_pulse", done_total - dn0, 1);

    // Move back to 100: 400 legal CCW quarter steps
    cw0 = cw_total; ccw0 = ccw_total; bad0 = bad_total;
    send_cmd(1'b0, 100);
    wait_done("mv100_done", 500 * P);
    chk_val("mv100_ccw", ccw_total - ccw0, 400);
    chk_val("mv100_cw", cw_total - cw0, 0);
    chk_val("mv100_bad", bad_total - bad0, 0);
    chk_val("mv100_emu", emu_pos, 120);
    chk_val("mv100_pos", int'(position_out), 100);

    // Move to 1005 runs into the far switch at 1000
    dn0 = done_total;
    send_cmd(1'b0, 1005);
    wait_err("far_err", 1000 * P);
    chk_val("far_pos", int'(position_out), 1000);
    chk_val("far_en", int'(stp_en_out), 0);
    chk_val("far_homed", int'(homed_out), 0);
    chk_val("far_busy", int'(busy_out), 0);
    chk_val("far_emu", emu_pos, 1020);
    chk_val("far_no_done", done_total - dn0, 0);
    clear_err("far_clear");

    // Homing timeout with near held low: 50 CCW steps, then ERROR
    near_force_low = 1'b1;
    repeat (4) @(negedge clock);
    ccw0 = ccw_total;
    send_cmd(1'b1, 0);
    wait_err("tmo_err", 100 * P);
    chk_val("tmo_ccw", ccw_total - ccw0, HT);
    chk_val("tmo_emu", emu_pos, 970);
    clear_err("tmo_clear");
    near_force_low = 1'b0;

    // Rehome from the near switch, then reset in the middle of a move
    @(negedge clock);
    emu_load_val = 0;
    emu_load = 1'b1;
    @(negedge clock);
    emu_load = 1'b0;
    repeat (4) @(negedge clock);
    send_cmd(1'b1, 0);
    wait_done("rehome_done", 40 * P);
    send_cmd(1'b0, 300);
    repeat (10 * P) @(posedge clock);
    #1;
    chk_val("mid_busy", int'(busy_out), 1);
    chk_val("mid_pos_nonzero", int'(position_out != '0), 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk_val("arst_en", int'(stp_en_out), 0);
    chk_val("arst_phase", int'({stp_pa_out, stp_pb_out}), 0);
    chk_val("arst_pos", int'(position_out), 0);
    chk_val("arst_flags", int'({homed_out, busy_out, done_out, error_out}), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    dn0 = done_total;
    repeat (5 * P) @(posedge clock);
    #1;
    chk_val("arst_no_done", done_total - dn0, 0);
    chk_val("arst_idle_busy", int'(busy_out), 0);
    chk_val("arst_idle_ready", int'(cmd_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
